// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with priority next-PC select, EPC and circular RAS
module pc_sequencer #(
   parameter int unsigned N            = 32,
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Hazard_flag,
   input  logic         Exception,
   input  logic [N-1:0] ExcPC,
   input  logic         Eret,
   input  logic         Redirect,
   input  logic [N-1:0] RedirectPC,
   input  logic         Link,
   input  logic         Ret,
   output logic [N-1:0] PCValue,
   output logic [N-1:0] PCPlus4,
   output logic [N-1:0] EPC,
   output logic         RasEmpty,
   output logic         RasFull
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N-1:0]  pc_q, pc_d, epc_q, epc_d;
   logic [N-1:0]  ras_q [DEPTH];
   logic [N-1:0]  ras_d [DEPTH];
   logic [AW-1:0] top_q, top_d, top_inc;
   logic [CW-1:0] cnt_q, cnt_d;

   assign PCValue  = pc_q;
   assign EPC      = epc_q;
   assign PCPlus4  = pc_q + N'(4);
   assign RasEmpty = cnt_q == '0;
   assign RasFull  = cnt_q == CW'(DEPTH);
   assign top_inc  = top_q + AW'(1);

   // next-state select: exception > eret > stall > redirect(+push) > pop > increment
   always_comb begin
      pc_d  = PCPlus4;
      epc_d = epc_q;
      ras_d = ras_q;
      top_d = top_q;
      cnt_d = cnt_q;
      if (Exception) begin
         pc_d  = N'(EXC_VECTOR);
         epc_d = ExcPC;
      end else if (Eret) begin
         pc_d = epc_q;
      end else if (Hazard_flag) begin
         pc_d = pc_q;
      end else if (Redirect) begin
         pc_d = RedirectPC & ~N'(3);
         if (Link) begin
            ras_d[top_inc] = PCPlus4;
            top_d          = top_inc;
            cnt_d          = RasFull ? cnt_q : cnt_q + CW'(1);
         end
      end else if (Ret && !RasEmpty) begin
         pc_d  = ras_q[top_q];
         top_d = top_q - AW'(1);
         cnt_d = cnt_q - CW'(1);
      end
   end

   // state registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= N'(RESET_VECTOR);
         epc_q <= '0;
         ras_q <= '{default: '0};
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         ras_q <= ras_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, RAS overflow/async-reset sequences, random run vs queue model
module tb_pc_sequencer;
   localparam logic [31:0] RV = 32'h0040_0000;
   localparam logic [31:0] EV = 32'h8000_0180;
   localparam int DEPTH = 4;

   logic        clk = 0, reset = 0;
   logic        hz = 0, exc = 0, eret = 0, red = 0, link = 0, ret = 0;
   logic [31:0] xpc = 0, rpc = 0;
   logic [31:0] pcv, pcp4, epc;
   logic        emp, full;
   int          checks = 0, errors = 0;

   typedef struct {
      logic hz, ex, er, rd, lk, rt;
      logic [31:0] rpc, xpc, pc, epc;
      logic emp, full;
   } vec_t;
   vec_t tbl[$];

   logic [31:0] m_pc, m_epc;
   logic [31:0] m_ras[$];

   pc_sequencer #(.N(32), .DEPTH(DEPTH), .RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
      .clk(clk), .reset(reset), .Hazard_flag(hz), .Exception(exc), .ExcPC(xpc),
      .Eret(eret), .Redirect(red), .RedirectPC(rpc), .Link(link), .Ret(ret),
      .PCValue(pcv), .PCPlus4(pcp4), .EPC(epc), .RasEmpty(emp), .RasFull(full)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(logic h, logic e, logic r, logic d, logic l, logic t,
                              logic [31:0] a, logic [31:0] x, logic [31:0] p, logic [31:0] ep,
                              logic em, logic fu);
      vec_t o;
      o.hz = h; o.ex = e; o.er = r; o.rd = d; o.lk = l; o.rt = t;
      o.rpc = a; o.xpc = x; o.pc = p; o.epc = ep; o.emp = em; o.full = fu;
      return o;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic h, logic e, logic r, logic d, logic l, logic t, logic [31:0] a, logic [31:0] x);
      hz = h; exc = e; eret = r; red = d; link = l; ret = t; rpc = a; xpc = x;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: unbounded list of return addresses trimmed to the newest DEPTH
   task automatic model_step();
      if (exc) begin
         m_pc = EV; m_epc = xpc;
      end else if (eret) begin
         m_pc = m_epc;
      end else if (hz) begin
      end else if (red) begin
         if (link) begin
            m_ras.push_back(m_pc + 4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
         m_pc = {rpc[31:2], 2'b00};
      end else if (ret && m_ras.size() > 0) begin
         m_pc = m_ras.pop_back();
      end else begin
         m_pc = m_pc + 4;
      end
   endtask

   initial begin
      logic [31:0] pcs[6];
      tbl.push_back(v(0,0,0,0,0,0, 0, 0, 32'h00400004, 0, 1, 0));
      tbl.push_back(v(0,0,0,0,0,0, 0, 0, 32'h00400008, 0, 1, 0));
      tbl.push_back(v(0,0,0,1,0,0, 32'h00400010, 0, 32'h00400010, 0, 1, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(v(1,0,0,0,0,0, 0, 0, 32'h00400010, 0, 1, 0));
      tbl.push_back(v(0,0,0,1,0,0, 32'h00400103, 0, 32'h00400100, 0, 1, 0));
      tbl.push_back(v(0,0,0,1,0,0, 32'h00400020, 0, 32'h00400020, 0, 1, 0));
      tbl.push_back(v(0,0,0,1,1,0, 32'h00400200, 0, 32'h00400200, 0, 0, 0));
      tbl.push_back(v(0,0,0,0,0,0, 0, 0, 32'h00400204, 0, 0, 0));
      tbl.push_back(v(0,0,0,0,0,0, 0, 0, 32'h00400208, 0, 0, 0));
      tbl.push_back(v(0,0,0,0,0,1, 0, 0, 32'h00400024, 0, 1, 0));
      tbl.push_back(v(0,0,0,1,0,0, 32'h00400030, 0, 32'h00400030, 0, 1, 0));
      tbl.push_back(v(0,0,0,0,0,1, 0, 0, 32'h00400034, 0, 1, 0));
      tbl.push_back(v(0,0,0,1,1,0, 32'h00400300, 0, 32'h00400300, 0, 0, 0));
      tbl.push_back(v(1,0,0,1,1,1, 32'h00400500, 0, 32'h00400300, 0, 0, 0));
      tbl.push_back(v(0,0,0,1,0,1, 32'h00400400, 0, 32'h00400400, 0, 0, 0));
      tbl.push_back(v(0,0,0,0,0,1, 0, 0, 32'h00400038, 0, 1, 0));
      tbl.push_back(v(1,1,0,0,0,0, 0, 32'h00400044, 32'h80000180, 32'h00400044, 1, 0));
      tbl.push_back(v(0,0,1,0,0,0, 0, 0, 32'h00400044, 32'h00400044, 1, 0));
      tbl.push_back(v(0,1,1,0,0,0, 0, 32'h00400060, 32'h80000180, 32'h00400060, 1, 0));
      tbl.push_back(v(0,0,1,0,0,0, 0, 0, 32'h00400060, 32'h00400060, 1, 0));
      tbl.push_back(v(0,0,0,1,0,0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h00400060, 1, 0));
      tbl.push_back(v(0,0,0,0,0,0, 0, 0, 32'h00000000, 32'h00400060, 1, 0));

      repeat (2) tick();
      chk("rst_pc", pcv, RV);
      chk("rst_epc", epc, 0);
      chk("rst_plus4", pcp4, RV + 4);
      chk("rst_empty", emp, 1);
      chk("rst_full", full, 0);
      reset = 1;

      foreach (tbl[i]) begin
         drive(tbl[i].hz, tbl[i].ex, tbl[i].er, tbl[i].rd, tbl[i].lk, tbl[i].rt, tbl[i].rpc, tbl[i].xpc);
         tick();
         chk($sformatf("vec%0d_pc", i), pcv, tbl[i].pc);
         chk($sformatf("vec%0d_plus4", i), pcp4, tbl[i].pc + 4);
         chk($sformatf("vec%0d_epc", i), epc, tbl[i].epc);
         chk($sformatf("vec%0d_empty", i), emp, tbl[i].emp);
         chk($sformatf("vec%0d_full", i), full, tbl[i].full);
      end
      drive(0,0,0,0,0,0,0,0);

      // async reset between edges, then held across an edge
      tick();
      drive(0,0,0,1,1,0, 32'h00400700, 0);
      #2 reset = 0;
      #1;
      chk("async_pc", pcv, RV);
      chk("async_epc", epc, 0);
      chk("async_empty", emp, 1);
      tick();
      chk("async_hold_pc", pcv, RV);
      chk("async_hold_empty", emp, 1);
      drive(0,0,0,0,0,0,0,0);
      reset = 1;
      tick();
      chk("post_rst_pc", pcv, RV + 4);

      // RAS overflow: five linking calls from A..E, then four returns
      for (int i = 0; i < 6; i++) pcs[i] = 32'h00401000 + 32'h100 * i;
      drive(0,0,0,1,0,0, pcs[0], 0);
      tick();
      for (int i = 1; i < 6; i++) begin
         drive(0,0,0,1,1,0, pcs[i], 0);
         tick();
      end
      chk("ovf_full", full, 1);
      chk("ovf_pc", pcv, pcs[5]);
      drive(0,0,0,0,0,1,0,0);
      for (int i = 4; i >= 1; i--) begin
         tick();
         chk($sformatf("ovf_ret%0d", i), pcv, pcs[i] + 4);
      end
      chk("ovf_empty", emp, 1);
      chk("ovf_notfull", full, 0);
      tick();
      chk("ovf_underflow", pcv, pcs[1] + 8);

      // push then immediate pop
      drive(0,0,0,1,1,0, 32'h00402000, 0);
      tick();
      drive(0,0,0,0,0,1,0,0);
      tick();
      chk("push_pop", pcv, pcs[1] + 12);
      drive(0,0,0,0,0,0,0,0);

      // randomized run against the model
      reset = 0;
      #1 reset = 1;
      m_pc = RV; m_epc = 0; m_ras.delete();
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0,99) < 20, $urandom_range(0,99) < 5, $urandom_range(0,99) < 6,
               $urandom_range(0,99) < 30, $urandom_range(0,99) < 50, $urandom_range(0,99) < 35,
               ($urandom_range(0,9) == 0) ? 32'hFFFFFFF8 | $urandom_range(0,7) : $urandom, $urandom);
         model_step();
         tick();
         chk("rnd_pc", pcv, m_pc);
         chk("rnd_epc", epc, m_epc);
         chk("rnd_empty", emp, m_ras.size() == 0);
         chk("rnd_full", full, m_ras.size() == DEPTH);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS core's fetch stage, replacing the fixed 32-bit hold/load PC register. It holds the fetch address and selects the next PC from several sources in a fixed priority order: exception entry, exception return, hazard stall, external redirect, return-address-stack pop, and sequential increment. A DEPTH-entry circular return-address stack (RAS) is pushed on linking redirects (jal/jalr) and popped on predicted returns (jr $ra). An EPC register captures the faulting PC on exception entry.

## Interface
- N, 32, PC/address width in bits (≥ 8)
- DEPTH, 4, RAS entries; power of two, ≥ 2
- RESET_VECTOR, 32'h0040_0000, PCValue after reset (truncated to N)
- EXC_VECTOR, 32'h8000_0180, exception entry address (truncated to N)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- Hazard_flag  in  1  stall: hold PC and RAS
- Exception  in  1  take exception this cycle
- ExcPC  in  N  faulting PC to capture into EPC
- Eret  in  1  return from exception
- Redirect  in  1  load RedirectPC (branch/jump resolved)
- RedirectPC  in  N  redirect target
- Link  in  1  qualifies Redirect: push PCValue+4 onto RAS
- Ret  in  1  predicted return: pop RAS top into PC
- PCValue  out  N  current fetch address (registered)
- PCPlus4  out  N  PCValue+4 mod 2^N (combinational)
- EPC  out  N  exception PC (registered)
- RasEmpty  out  1  RAS count == 0 (combinational from state)
- RasFull  out  1  RAS count == DEPTH (combinational from state)

## Operation
- Reset: PCValue=RESET_VECTOR, EPC=0, RAS count=0, top pointer=0, all RAS entries=0. RasEmpty=1, RasFull=0.
- Next-PC priority per rising edge (first match wins):
  1. Exception: PC←EXC_VECTOR, EPC←ExcPC. Overrides Hazard_flag. RAS unchanged.
  2. Eret: PC←EPC (value before this edge). Overrides Hazard_flag. RAS unchanged.
  3. Hazard_flag: PC, EPC and RAS hold. Redirect, Link and Ret are ignored.
  4. Redirect: PC←{RedirectPC[N-1:2],2'b00}. If Link=1, push PCValue+4.
  5. Ret and count>0: PC←RAS top, pop.
  6. Ret and count==0: PC←PCPlus4, no pop (underflow is benign).
  7. Otherwise: PC←PCPlus4.
- Link without Redirect has no effect. Ret together with Redirect: Redirect wins and no pop occurs.
- RAS is circular. A push writes at top+1 (mod DEPTH), advances top, and count saturates at DEPTH. A push when full overwrites the oldest entry. A pop reads entry[top], retreats top (mod DEPTH), and decrements count.
- All arithmetic is unsigned modulo 2^N. Increment wraps from 2^N-4 to 0 with no flag.

## Timing
- Single cycle: inputs sampled at the rising edge of clk, so PCValue, EPC and RAS update one edge later. PCPlus4, RasEmpty and RasFull follow the registered state combinationally.
- Asserting reset (low) mid-operation forces reset values asynchronously, independent of clk. The first update happens on the first rising edge after reset goes high.
- An exception asserted while Hazard_flag=1 takes effect on that same edge.
- Back-to-back push then pop on consecutive edges returns the value just pushed.

## Test plan
- Reset/sequential: hold reset low then release, with no other inputs -> PCValue=0x00400000, then 0x00400004, 0x00400008. Pulse reset low mid-run -> PCValue returns to 0x00400000 immediately.
- Stall/redirect: Hazard_flag=1 for 3 cycles at 0x00400010 -> PC holds at 0x00400010. Redirect=1 with RedirectPC=0x00400103 -> PC=0x00400100. Redirect and Ret asserted together -> redirect taken, RAS count unchanged.
- Call/return: Redirect+Link at PC 0x00400020 to 0x00400200, run 2 cycles, then Ret -> PC=0x00400024, RasEmpty=1. Ret on empty RAS at 0x00400030 -> PC=0x00400034.
- RAS overflow (DEPTH=4): 5 linking redirects from PCs A..E -> RasFull=1. 4 Rets -> PCs E+4, D+4, C+4, B+4, then RasEmpty=1 (A+4 lost).
- Exception/eret: Exception with ExcPC=0x00400044 while Hazard_flag=1 -> PC=0x80000180, EPC=0x00400044. Eret -> PC=0x00400044. Exception and Eret asserted together -> exception wins.
- Wrap: N=32, PC forced via redirect to 0xFFFFFFFC -> next PC=0x00000000.
